// File: rtl/tour_cmd_sequencer.sv
// rtl/tour_cmd_sequencer.sv - command queue playback sequencer feeding RemoteComm
module tour_cmd_sequencer #(
  parameter int         DEPTH    = 8,
  parameter logic [7:0] ACK      = 8'hA5,
  parameter int         TMO_CLKS = 1_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       ld_cmd,
  input  logic [15:0]                cmd_in,
  input  logic                       start,
  input  logic                       abort,
  output logic                       snd_cmd,
  output logic [15:0]                cmd,
  input  logic                       cmd_snt,
  input  logic                       resp_rdy,
  input  logic [7:0]                 resp,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic [$clog2(DEPTH)-1:0]   cur_idx,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [1:0]                 err_code
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int TW = $clog2(TMO_CLKS) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CLKS - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SEND      = 3'd1;
  localparam logic [2:0] S_WAIT_SNT  = 3'd2;
  localparam logic [2:0] S_WAIT_RESP = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;
  localparam logic [2:0] S_ERR       = 3'd5;

  localparam logic [1:0] E_NACK  = 2'b01;
  localparam logic [1:0] E_TMO   = 2'b10;
  localparam logic [1:0] E_ABORT = 2'b11;

  logic [2:0]    r_state;
  logic [15:0]   r_mem [DEPTH];
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_cur_idx;
  logic [15:0]   r_cmd;
  logic          r_err;
  logic [1:0]    r_err_code;
  logic [TW-1:0] r_tmo;

  logic          w_busy;
  logic          w_full;
  logic          w_last;
  logic          w_tmo_hit;
  logic [IW-1:0] w_nxt_idx;

  assign w_busy    = (r_state == S_SEND) || (r_state == S_WAIT_SNT) || (r_state == S_WAIT_RESP);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_last    = ({1'b0, r_cur_idx} == (r_count - CW'(1)));
  assign w_tmo_hit = (r_tmo == TMO_LAST);
  assign w_nxt_idx = r_cur_idx + IW'(1);

  assign snd_cmd  = (r_state == S_SEND);
  assign done     = (r_state == S_DONE);
  assign busy     = w_busy;
  assign full     = w_full;
  assign count    = r_count;
  assign cur_idx  = r_cur_idx;
  assign cmd      = r_cmd;
  assign err      = r_err;
  assign err_code = r_err_code;

  // Queue storage: loads and clears only while idle; clr beats ld_cmd, a full queue drops loads
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (!w_busy) begin
      if (clr) begin
        r_count <= '0;
      end else if (ld_cmd && !w_full) begin
        r_mem[r_count[IW-1:0]] <= cmd_in;
        r_count                <= r_count + CW'(1);
      end
    end
  end

  // Playback FSM: abort beats events, events beat the timeout terminal count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cur_idx  <= '0;
      r_cmd      <= '0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
      r_tmo      <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
            r_cur_idx  <= '0;
            if (r_count != '0) begin
              r_cmd   <= r_mem[0];
              r_state <= S_SEND;
            end else begin
              r_state <= S_DONE;
            end
          end else if (r_state == S_DONE) begin
            r_state <= S_IDLE;
          end
        end
        S_SEND: begin
          r_tmo <= '0;
          if (abort) begin
            r_state    <= S_ERR;
            r_err      <= 1'b1;
            r_err_code <= E_ABORT;
          end else begin
            r_state <= S_WAIT_SNT;
          end
        end
        S_WAIT_SNT: begin
          if (abort) begin
            r_state    <= S_ERR;
            r_err      <= 1'b1;
            r_err_code <= E_ABORT;
          end else if (cmd_snt) begin
            r_state <= S_WAIT_RESP;
            r_tmo   <= '0;
          end else if (w_tmo_hit) begin
            r_state    <= S_ERR;
            r_err      <= 1'b1;
            r_err_code <= E_TMO;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_WAIT_RESP: begin
          if (abort) begin
            r_state    <= S_ERR;
            r_err      <= 1'b1;
            r_err_code <= E_ABORT;
          end else if (resp_rdy) begin
            if (resp != ACK) begin
              r_state    <= S_ERR;
              r_err      <= 1'b1;
              r_err_code <= E_NACK;
            end else if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_cur_idx <= w_nxt_idx;
              r_cmd     <= r_mem[w_nxt_idx];
              r_state   <= S_SEND;
            end
          end else if (w_tmo_hit) begin
            r_state    <= S_ERR;
            r_err      <= 1'b1;
            r_err_code <= E_TMO;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// tb/tb_tour_cmd_sequencer.sv - directed self-checking bench for tour_cmd_sequencer
module tb_tour_cmd_sequencer;

  localparam int DEPTH = 8;
  localparam int TMO   = 100;

  logic        clk = 1'b0;
  logic        rst, clr, ld_cmd, start, abort, cmd_snt, resp_rdy;
  logic [15:0] cmd_in;
  logic [7:0]  resp;
  logic        snd_cmd;
  logic [15:0] cmd;
  logic [3:0]  count;
  logic        full;
  logic [2:0]  cur_idx;
  logic        busy, done, err;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;
  int snd_cnt = 0;
  int done_cnt = 0;

  tour_cmd_sequencer #(.DEPTH(DEPTH), .ACK(8'hA5), .TMO_CLKS(TMO)) dut (
    .clk(clk), .rst(rst), .clr(clr), .ld_cmd(ld_cmd), .cmd_in(cmd_in),
    .start(start), .abort(abort), .snd_cmd(snd_cmd), .cmd(cmd),
    .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp), .count(count),
    .full(full), .cur_idx(cur_idx), .busy(busy), .done(done), .err(err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (snd_cmd) snd_cnt++;
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; ld_cmd = 1'b0; start = 1'b0; abort = 1'b0;
    cmd_snt = 1'b0; resp_rdy = 1'b0; cmd_in = 16'h0; resp = 8'h0;
    tick();
    rst = 1'b0;
  endtask

  task automatic load(input logic [15:0] v);
    ld_cmd = 1'b1; cmd_in = v;
    tick();
    ld_cmd = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // From SEND: walk WAIT_SNT and WAIT_RESP, answering with byte r
  task automatic respond(input logic [7:0] r);
    tick();
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
    resp_rdy = 1'b1; resp = r;
    tick();
    resp_rdy = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({count, full, cur_idx, busy, done, err, err_code, snd_cmd} !== 14'h0) begin
      errors++;
      $display("FAIL reset_flags got count=%0d full=%0b idx=%0d busy=%0b done=%0b err=%0b code=%0b snd=%0b want all 0",
               count, full, cur_idx, busy, done, err, err_code, snd_cmd);
    end
    checks++;
    if (cmd !== 16'h0000) begin errors++; $display("FAIL reset_cmd got %h want 0000", cmd); end
  endtask

  task automatic test_two_ack();
    int s0, d0;
    do_reset();
    load(16'h4001);
    load(16'h5BF1);
    checks++;
    if (count !== 4'd2) begin errors++; $display("FAIL load_count got %0d want 2", count); end
    s0 = snd_cnt; d0 = done_cnt;
    pulse_start();
    checks++;
    if (!(snd_cmd === 1'b1 && cmd === 16'h4001 && busy === 1'b1)) begin
      errors++; $display("FAIL first_send got snd=%0b cmd=%h busy=%0b want 1 4001 1", snd_cmd, cmd, busy);
    end
    tick();
    checks++;
    if (!(snd_cmd === 1'b0 && cmd === 16'h4001)) begin
      errors++; $display("FAIL cmd_hold got snd=%0b cmd=%h want 0 4001", snd_cmd, cmd);
    end
    cmd_snt = 1'b1; tick(); cmd_snt = 1'b0;
    resp_rdy = 1'b1; resp = 8'hA5; tick(); resp_rdy = 1'b0;
    checks++;
    if (!(snd_cmd === 1'b1 && cmd === 16'h5BF1 && cur_idx === 3'd1)) begin
      errors++; $display("FAIL second_send got snd=%0b cmd=%h idx=%0d want 1 5bf1 1", snd_cmd, cmd, cur_idx);
    end
    respond(8'hA5);
    checks++;
    if (!(done === 1'b1 && busy === 1'b0)) begin
      errors++; $display("FAIL done_pulse got done=%0b busy=%0b want 1 0", done, busy);
    end
    tick();
    tick();
    checks++;
    if (!(done === 1'b0 && err === 1'b0 && count === 4'd2)) begin
      errors++; $display("FAIL after_done got done=%0b err=%0b count=%0d want 0 0 2", done, err, count);
    end
    checks++;
    if (snd_cnt - s0 != 2 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL pulse_counts got snd=%0d done=%0d want 2 1", snd_cnt - s0, done_cnt - d0);
    end
  endtask

  task automatic test_nack();
    int s0;
    do_reset();
    load(16'h1111); load(16'h2222); load(16'h3333);
    s0 = snd_cnt;
    pulse_start();
    respond(8'hA5);
    respond(8'h5A);
    checks++;
    if (!(err === 1'b1 && err_code === 2'b01 && cur_idx === 3'd1 && busy === 1'b0)) begin
      errors++; $display("FAIL nack got err=%0b code=%0b idx=%0d busy=%0b want 1 01 1 0", err, err_code, cur_idx, busy);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    repeat (4) tick();
    checks++;
    if (!(err_code === 2'b01 && cur_idx === 3'd1 && snd_cnt - s0 == 2)) begin
      errors++; $display("FAIL nack_hold got code=%0b idx=%0d snd=%0d want 01 1 2", err_code, cur_idx, snd_cnt - s0);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    load(16'h7777);
    pulse_start();
    tick();
    resp_rdy = 1'b1; resp = 8'hA5;
    tick();
    resp_rdy = 1'b0;
    repeat (98) tick();
    checks++;
    if (!(busy === 1'b1 && err === 1'b0)) begin
      errors++; $display("FAIL tmo_early got busy=%0b err=%0b want 1 0", busy, err);
    end
    tick();
    checks++;
    if (!(err === 1'b1 && err_code === 2'b10 && busy === 1'b0)) begin
      errors++; $display("FAIL tmo_fire got err=%0b code=%0b busy=%0b want 1 10 0", err, err_code, busy);
    end
  endtask

  task automatic test_tmo_edge();
    do_reset();
    load(16'h8888);
    pulse_start();
    tick();
    repeat (99) tick();
    cmd_snt = 1'b1; tick(); cmd_snt = 1'b0;
    checks++;
    if (!(busy === 1'b1 && err === 1'b0)) begin
      errors++; $display("FAIL event_beats_tmo got busy=%0b err=%0b want 1 0", busy, err);
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_abort_replay();
    do_reset();
    load(16'hA001); load(16'hA002);
    pulse_start();
    tick();
    cmd_snt = 1'b1; tick(); cmd_snt = 1'b0;
    resp_rdy = 1'b1; resp = 8'hA5; abort = 1'b1;
    tick();
    resp_rdy = 1'b0; abort = 1'b0;
    checks++;
    if (!(err === 1'b1 && err_code === 2'b11 && cur_idx === 3'd0)) begin
      errors++; $display("FAIL abort got err=%0b code=%0b idx=%0d want 1 11 0", err, err_code, cur_idx);
    end
    pulse_start();
    checks++;
    if (!(snd_cmd === 1'b1 && cmd === 16'hA001 && err === 1'b0 && err_code === 2'b00)) begin
      errors++; $display("FAIL replay got snd=%0b cmd=%h err=%0b code=%0b want 1 a001 0 00", snd_cmd, cmd, err, err_code);
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_full_empty();
    int s0, d0;
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) load(16'h0100 + 16'(i));
    checks++;
    if (!(full === 1'b1 && count === 4'd8)) begin
      errors++; $display("FAIL full got full=%0b count=%0d want 1 8", full, count);
    end
    pulse_start();
    checks++;
    if (cmd !== 16'h0100) begin errors++; $display("FAIL entry0_kept got %h want 0100", cmd); end
    clr = 1'b1; ld_cmd = 1'b1; cmd_in = 16'hDEAD;
    tick();
    clr = 1'b0; ld_cmd = 1'b0;
    checks++;
    if (count !== 4'd8) begin errors++; $display("FAIL busy_ignores_ld_clr got %0d want 8", count); end
    abort = 1'b1; tick(); abort = 1'b0;
    clr = 1'b1; ld_cmd = 1'b1; tick(); clr = 1'b0; ld_cmd = 1'b0;
    checks++;
    if (!(count === 4'd0 && full === 1'b0)) begin
      errors++; $display("FAIL clr got count=%0d full=%0b want 0 0", count, full);
    end
    s0 = snd_cnt; d0 = done_cnt;
    pulse_start();
    checks++;
    if (!(done === 1'b1 && snd_cmd === 1'b0)) begin
      errors++; $display("FAIL empty_start got done=%0b snd=%0b want 1 0", done, snd_cmd);
    end
    tick(); tick();
    checks++;
    if (!(snd_cnt - s0 == 0 && done_cnt - d0 == 1 && busy === 1'b0)) begin
      errors++; $display("FAIL empty_counts got snd=%0d done=%0d busy=%0b want 0 1 0", snd_cnt - s0, done_cnt - d0, busy);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    do_reset();
    load(16'hBEEF);
    pulse_start();
    tick();
    cmd_snt = 1'b1; tick(); cmd_snt = 1'b0;
    d0 = done_cnt;
    rst = 1'b1; tick(); rst = 1'b0;
    resp_rdy = 1'b1; resp = 8'hA5; tick(); resp_rdy = 1'b0;
    tick();
    checks++;
    if ({count, full, cur_idx, busy, done, err, err_code, snd_cmd} !== 14'h0 || cmd !== 16'h0000) begin
      errors++; $display("FAIL rst_mid got count=%0d busy=%0b err=%0b code=%0b snd=%0b cmd=%h want all 0",
                         count, busy, err, err_code, snd_cmd, cmd);
    end
    checks++;
    if (done_cnt - d0 != 0) begin errors++; $display("FAIL rst_mid_done got %0d want 0", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_two_ack();
    test_nack();
    test_timeout();
    test_tmo_edge();
    test_abort_replay();
    test_full_empty();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tour_cmd_sequencer.md
TOUR_CMD_SEQUENCER -- requirements
Module: tour_cmd_sequencer

Interface
REQ-001 Parameters (name, default, meaning):
- DEPTH, 8: command queue entries; power of two.
- ACK, 8'hA5: positive-acknowledge byte.
- TMO_CLKS, 1_000_000: max clocks per wait state; counter width is $clog2(TMO_CLKS)+1.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: system clock.
- rst, in, 1: reset; synchronous, active-high (already decided; polarity and synchronicity fixed).
- clr, in, 1: empty the queue (honoured only when busy=0).
- ld_cmd, in, 1: push cmd_in into the queue.
- cmd_in, in, 16: command to queue.
- start, in, 1: begin playback from entry 0.
- abort, in, 1: stop playback.
- snd_cmd, out, 1: one-cycle send request to RemoteComm.
- cmd, out, 16: command presented to RemoteComm.
- cmd_snt, in, 1: RemoteComm finished transmitting.
- resp_rdy, in, 1: response byte valid.
- resp, in, 8: response byte.
- count, out, $clog2(DEPTH)+1: number of queued entries.
- full, out, 1: count==DEPTH.
- cur_idx, out, $clog2(DEPTH): entry currently in flight.
- busy, out, 1: playback in progress.
- done, out, 1: one-cycle pulse when playback completes.
- err, out, 1: sticky error flag.
- err_code, out, 2: 00 none, 01 NACK, 10 timeout, 11 abort.

Function
REQ-003 States: IDLE, SEND, WAIT_SNT, WAIT_RESP, DONE, ERR; one state register.
REQ-004 Queue loading:
- ld_cmd with busy=0 and full=0 writes cmd_in at index count and increments count next cycle.
- ld_cmd while busy=1 or full=1 is ignored; queue and count are unchanged.
REQ-005 clr with busy=0 sets count to 0 next cycle; clr and ld_cmd in the same cycle: clr wins.
REQ-006 start in IDLE, DONE or ERR:
- with count>0: next cycle cur_idx=0, err=0, err_code=00, state SEND.
- with count==0: done pulses for one cycle; snd_cmd is never asserted.
REQ-007 start while busy=1 is ignored.
REQ-008 SEND lasts exactly one cycle:
- snd_cmd=1 and cmd=queue[cur_idx].
- next state WAIT_SNT.
REQ-009 cmd holds queue[cur_idx] from SEND until the state after WAIT_RESP.
REQ-010 WAIT_SNT: cmd_snt -> WAIT_RESP next cycle; resp_rdy in this state is ignored.
REQ-011 WAIT_RESP on resp_rdy:
- resp==ACK and cur_idx<count-1: increment cur_idx, go to SEND.
- resp==ACK and cur_idx==count-1: go to DONE.
- resp!=ACK: go to ERR with err_code=01.
REQ-012 Timeout counter:
- clears on entry to WAIT_SNT and WAIT_RESP; increments each cycle in those states.
- reaching TMO_CLKS-1 without the awaited event: ERR with err_code=10.
REQ-013 Awaited event and terminal count in the same cycle: the event wins.
REQ-014 abort in SEND, WAIT_SNT or WAIT_RESP -> ERR with err_code=11 next cycle; abort overrides cmd_snt, resp_rdy and timeout in that cycle. abort in IDLE, DONE or ERR is ignored.
REQ-015 DONE: done=1 for exactly one cycle, then IDLE; queue contents and count are retained so the tour can be replayed.
REQ-016 ERR: err=1; err_code and cur_idx hold the failing entry until the next accepted start or rst; no snd_cmd is issued.
REQ-017 busy=1 exactly in SEND, WAIT_SNT and WAIT_RESP.
REQ-018 Latency: start to first snd_cmd is 1 cycle; resp_rdy(ACK) to next snd_cmd is 1 cycle.
REQ-019 At most one snd_cmd per outstanding entry; a new snd_cmd is never issued before the previous response is consumed.

Reset
REQ-020 rst=1 at a clock edge forces IDLE, count=0, cur_idx=0, snd_cmd=0, cmd=16'h0000, busy=0, done=0, err=0, err_code=00, timeout counter=0.
REQ-021 rst mid-playback, including during WAIT_RESP, discards the in-flight command; a later resp_rdy is ignored.
REQ-022 rst overrides every other input in the same cycle.

Verification
REQ-023 Load 16'h4001, 16'h5BF1; start; ACK both:
- snd_cmd pulses twice, with cmd=4001 then 5BF1.
- done pulses once; err=0; count=2.
REQ-024 Load 3 entries; ACK entry 0; resp=8'h5A on entry 1:
- err=1, err_code=01, cur_idx=1, busy=0.
- no third snd_cmd.
REQ-025 TMO_CLKS=100; load 1 entry; start; never assert cmd_snt:
- err_code=10 exactly 100 cycles after entering WAIT_SNT.
REQ-026 Abort in the same cycle as resp_rdy=ACK on entry 0 of 2:
- err_code=11, cur_idx=0.
- restart with start replays entry 0 first.
REQ-027 Load DEPTH+1 entries:
- full=1, count=DEPTH; the last entry is dropped.
- start with count==0 (after clr) gives a done pulse and no snd_cmd.
REQ-028 Assert rst during WAIT_RESP, then resp_rdy=ACK:
- all outputs at reset values; no done.
